control_unit: RTL and testbench
===============================

// Module: control_unit
// PURPOSE
//  Sequencing FSM for the 16-bit processor datapath. Owns the program counter (PC) and the
//  instruction register (IR). Fetches from instruction ROM, decodes IR[15:12], and drives
//  data-memory, register-file and ALU controls with single-cycle strobes.
//  Sits inside Processor between the instruction ROM and the datapath. State and PC also go
//  to the board hex display.
// PARAMETERS
//  PC_W     5   program counter width; ROM depth is 2**PC_W
//  DADDR_W  8   data memory address width (IR[11:4])
//  RADDR_W  4   register file address width (16 registers)
// PORTS
//  Clk        in   1        system clock, rising edge
//  Reset_n    in   1        asynchronous, active-low reset
//  I_Data     in   16       instruction ROM read data; combinational read of I_Addr
//  I_Addr     out  PC_W     ROM address; equals PC
//  I_Rd       out  1        ROM read enable; high in FETCH only
//  IR_Out     out  16       current instruction register
//  PC_Out     out  PC_W     current PC
//  StateO     out  4        state encoding, for display
//  D_Addr     out  DADDR_W  data memory address (IR[11:4]); 0 outside LOAD_A/LOAD_B/STORE
//  D_Wr       out  1        data memory write strobe
//  RF_s       out  1        register-file write mux: 1 = memory data, 0 = ALU result
//  RF_W_Addr  out  RADDR_W  register-file write address
//  RF_W_en    out  1        register-file write strobe
//  RF_Ra_Addr out  RADDR_W  register-file read port A address
//  RF_Rb_Addr out  RADDR_W  register-file read port B address
//  ALU_s0     out  3        ALU op: 0 = PASS_A, 1 = ADD, 2 = SUB
// BEHAVIOUR
//  - ISA, with op = IR[15:12]:
//      0 NOOP
//      1 STORE  D[IR[11:4]] <- R[IR[3:0]]
//      2 LOAD   R[IR[3:0]] <- D[IR[11:4]]
//      3 ADD    R[IR[3:0]] <- R[IR[11:8]] + R[IR[7:4]]
//      4 SUB    R[IR[3:0]] <- R[IR[11:8]] - R[IR[7:4]]
//      5 HALT
//      6-15 execute as NOOP
//  - States and StateO encoding:
//      INIT=0, FETCH=1, DECODE=2, NOOP=3, LOAD_A=4, LOAD_B=5,
//      STORE=6, ADD=7, SUB=8, HALT=9
//  - Reset (Reset_n low, asynchronous): state=INIT, PC=0, IR=0.
//    Every strobe and address output is 0 while in reset.
//  - All control outputs are Moore: decoded from state and IR only. No comb path from I_Data.
//  - INIT: PC cleared, goes to FETCH next cycle.
//  - FETCH: I_Rd=1. At the edge, IR<=I_Data and PC<=PC+1. PC wraps 2**PC_W-1 -> 0 silently.
//    Next state is DECODE.
//  - DECODE: no strobes. Next state is chosen from op.
//  - NOOP: one cycle, then FETCH.
//  - STORE: D_Addr=IR[11:4], RF_Ra_Addr=IR[3:0], D_Wr=1 for exactly 1 cycle, then FETCH.
//  - LOAD_A: D_Addr=IR[11:4], RF_s=1, RF_W_Addr=IR[3:0], RF_W_en=0 (memory read settles).
//  - LOAD_B: same outputs as LOAD_A, plus RF_W_en=1. Then FETCH.
//  - ADD/SUB: RF_Ra_Addr=IR[11:8], RF_Rb_Addr=IR[7:4], RF_W_Addr=IR[3:0], RF_s=0,
//    ALU_s0=1 (ADD) or 2 (SUB), RF_W_en=1 for 1 cycle, then FETCH.
//    Overflow is not detected; the result wraps mod 2**16 in the datapath.
//  - HALT: absorbing state. PC and IR are frozen and no strobes are issued. Only reset exits.
//  - Instruction cycle counts:
//      NOOP/STORE/ADD/SUB = 3 cycles (FETCH, DECODE, EXEC)
//      LOAD = 4 cycles
//  - Reset asserted mid-instruction aborts the instruction. Any pending D_Wr/RF_W_en is
//    dropped in the same instant. On release, execution restarts at INIT with PC=0.
//  - Exactly one of D_Wr or RF_W_en is high in any cycle, or neither.
// STRUCTURE
//  - Package ctrl_pkg holds:
//      opcode constants OP_NOOP..OP_HALT
//      state encoding constants S_INIT..S_HALT (4-bit)
//      ALU select constants ALU_PASS/ALU_ADD/ALU_SUB
//  - Sub-module pc_counter (PC_W): async clear, sync clear, increment enable, hold.
//  - The FSM (state register plus output decode) and the IR register stay in control_unit.
// TESTING
//  - Reset: Reset_n=0 mid-LOAD_B -> RF_W_en=0 at once, StateO=0, PC_Out=0, IR_Out=0.
//    After release: INIT, FETCH, with I_Addr=0.
//  - LOAD: ROM[0]=16'h2A53 -> FETCH, DECODE, LOAD_A, LOAD_B. D_Addr=8'hA5, RF_W_Addr=3,
//    RF_s=1. RF_W_en=1 only in LOAD_B. PC_Out=1.
//  - ADD/SUB: ROM=16'h3126, 16'h4126 -> ALU_s0=1, then 2. Ra=1, Rb=2, W=6, RF_W_en
//    exactly 1 cycle each. Six cycles total after the first FETCH.
//  - STORE/NOOP/illegal: ROM=16'h10F7, 16'h0000, 16'hE123 -> D_Wr once with D_Addr=8'h0F
//    and Ra=7. 16'hE123 behaves as NOOP (StateO=3), with no strobes.
//  - HALT: ROM[2]=16'h5000 -> StateO=9 held for 20+ cycles. PC_Out=3 is stable, I_Rd=0,
//    no strobes.
//  - Wrap: ROM filled with NOOP -> after PC 31, PC_Out=0. The next fetch reads ROM[0].

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings for the processor control unit: opcodes, FSM states, ALU selects.
package ctrl_pkg;

    localparam logic [3:0] OP_NOOP  = 4'd0;
    localparam logic [3:0] OP_STORE = 4'd1;
    localparam logic [3:0] OP_LOAD  = 4'd2;
    localparam logic [3:0] OP_ADD   = 4'd3;
    localparam logic [3:0] OP_SUB   = 4'd4;
    localparam logic [3:0] OP_HALT  = 4'd5;

    localparam logic [3:0] S_INIT   = 4'd0;
    localparam logic [3:0] S_FETCH  = 4'd1;
    localparam logic [3:0] S_DECODE = 4'd2;
    localparam logic [3:0] S_NOOP   = 4'd3;
    localparam logic [3:0] S_LOAD_A = 4'd4;
    localparam logic [3:0] S_LOAD_B = 4'd5;
    localparam logic [3:0] S_STORE  = 4'd6;
    localparam logic [3:0] S_ADD    = 4'd7;
    localparam logic [3:0] S_SUB    = 4'd8;
    localparam logic [3:0] S_HALT   = 4'd9;

    localparam logic [2:0] ALU_PASS = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_SUB  = 3'd2;

    // Opcodes 6-15 are not errors; they simply run as NOOP.
    function automatic logic [3:0] decode_state(input logic [3:0] op);
        case (op)
            OP_STORE: decode_state = S_STORE;
            OP_LOAD:  decode_state = S_LOAD_A;
            OP_ADD:   decode_state = S_ADD;
            OP_SUB:   decode_state = S_SUB;
            OP_HALT:  decode_state = S_HALT;
            default:  decode_state = S_NOOP;
        endcase
    endfunction

endpackage

// File: rtl/pc_counter.sv
// Program counter: async clear, sync clear, increment, otherwise hold. Wraps silently.
module pc_counter #(
    parameter int PC_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            inc,
    output logic [PC_W-1:0] pc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   pc <= '0;
        else if (clr) pc <= '0;
        else if (inc) pc <= pc + 1'b1;
    end

endmodule

// File: rtl/control_unit.sv
// Sequencing FSM for the 16-bit datapath: owns PC and IR, issues Moore control strobes.
module control_unit
    import ctrl_pkg::*;
#(
    parameter int PC_W    = 5,
    parameter int DADDR_W = 8,
    parameter int RADDR_W = 4
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic [15:0]        I_Data,
    output logic [PC_W-1:0]    I_Addr,
    output logic               I_Rd,
    output logic [15:0]        IR_Out,
    output logic [PC_W-1:0]    PC_Out,
    output logic [3:0]         StateO,
    output logic [DADDR_W-1:0] D_Addr,
    output logic               D_Wr,
    output logic               RF_s,
    output logic [RADDR_W-1:0] RF_W_Addr,
    output logic               RF_W_en,
    output logic [RADDR_W-1:0] RF_Ra_Addr,
    output logic [RADDR_W-1:0] RF_Rb_Addr,
    output logic [2:0]         ALU_s0
);

    logic [3:0]      state, state_nxt;
    logic [15:0]     ir;
    logic [PC_W-1:0] pc;

    pc_counter #(.PC_W(PC_W)) u_pc (
        .clk  (Clk),
        .rst_n(Reset_n),
        .clr  (state == S_INIT),
        .inc  (state == S_FETCH),
        .pc   (pc)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= S_INIT;
            ir    <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_FETCH) ir <= I_Data;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_INIT:   state_nxt = S_FETCH;
            S_FETCH:  state_nxt = S_DECODE;
            S_DECODE: state_nxt = decode_state(ir[15:12]);
            S_LOAD_A: state_nxt = S_LOAD_B;
            S_HALT:   state_nxt = S_HALT;
            S_NOOP, S_LOAD_B, S_STORE, S_ADD, S_SUB: state_nxt = S_FETCH;
            default:  state_nxt = S_INIT;
        endcase
    end

    // Outputs depend only on state and IR, so I_Data never reaches them combinationally.
    always_comb begin
        I_Rd       = (state == S_FETCH);
        D_Addr     = '0;
        D_Wr       = 1'b0;
        RF_s       = 1'b0;
        RF_W_Addr  = '0;
        RF_W_en    = 1'b0;
        RF_Ra_Addr = '0;
        RF_Rb_Addr = '0;
        ALU_s0     = ALU_PASS;
        case (state)
            S_STORE: begin
                D_Addr     = ir[4 +: DADDR_W];
                RF_Ra_Addr = ir[0 +: RADDR_W];
                D_Wr       = 1'b1;
            end
            S_LOAD_A, S_LOAD_B: begin
                D_Addr    = ir[4 +: DADDR_W];
                RF_s      = 1'b1;
                RF_W_Addr = ir[0 +: RADDR_W];
                RF_W_en   = (state == S_LOAD_B);
            end
            S_ADD, S_SUB: begin
                RF_Ra_Addr = ir[8 +: RADDR_W];
                RF_Rb_Addr = ir[4 +: RADDR_W];
                RF_W_Addr  = ir[0 +: RADDR_W];
                ALU_s0     = (state == S_ADD) ? ALU_ADD : ALU_SUB;
                RF_W_en    = 1'b1;
            end
            default: ;
        endcase
    end

    assign I_Addr = pc;
    assign PC_Out = pc;
    assign IR_Out = ir;
    assign StateO = state;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench: instruction-level model expands each instruction into its cycle trace.
module tb_control_unit;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic [15:0] I_Data;
    logic [4:0]  I_Addr, PC_Out;
    logic        I_Rd, D_Wr, RF_s, RF_W_en;
    logic [15:0] IR_Out;
    logic [3:0]  StateO, RF_W_Addr, RF_Ra_Addr, RF_Rb_Addr;
    logic [7:0]  D_Addr;
    logic [2:0]  ALU_s0;

    logic [15:0] rom [0:31];
    assign I_Data = rom[I_Addr];

    always #5 Clk = ~Clk;

    control_unit dut (
        .Clk(Clk), .Reset_n(Reset_n), .I_Data(I_Data), .I_Addr(I_Addr), .I_Rd(I_Rd),
        .IR_Out(IR_Out), .PC_Out(PC_Out), .StateO(StateO), .D_Addr(D_Addr), .D_Wr(D_Wr),
        .RF_s(RF_s), .RF_W_Addr(RF_W_Addr), .RF_W_en(RF_W_en), .RF_Ra_Addr(RF_Ra_Addr),
        .RF_Rb_Addr(RF_Rb_Addr), .ALU_s0(ALU_s0)
    );

    typedef struct packed {
        logic [3:0]  st;
        logic [4:0]  pc;
        logic [4:0]  i_addr;
        logic [15:0] ir;
        logic        i_rd;
        logic [7:0]  d_addr;
        logic        d_wr;
        logic        rf_s;
        logic [3:0]  wa;
        logic        wen;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [2:0]  alu;
    } obs_t;

    obs_t obs;
    always_comb obs = '{StateO, PC_Out, I_Addr, IR_Out, I_Rd, D_Addr, D_Wr, RF_s,
                        RF_W_Addr, RF_W_en, RF_Ra_Addr, RF_Rb_Addr, ALU_s0};

    obs_t exp_q [$];
    int   tests = 0;
    int   failed = 0;

    function automatic obs_t quiet(input int st, input int pc, input logic [15:0] ir);
        obs_t r = '0;
        r.st     = st[3:0];
        r.pc     = pc[4:0];
        r.i_addr = pc[4:0];
        r.ir     = ir;
        return r;
    endfunction

    // Walk the program one instruction at a time, appending the cycles it should take.
    task automatic build_expect(input int n);
        int pc = 0;
        logic [15:0] ir = '0;
        obs_t r;
        exp_q.delete();
        exp_q.push_back(quiet(0, 0, 16'h0));
        while (exp_q.size() < n) begin
            r = quiet(1, pc, ir); r.i_rd = 1'b1; exp_q.push_back(r);
            ir = rom[pc];
            pc = (pc + 1) % 32;
            exp_q.push_back(quiet(2, pc, ir));
            case (ir[15:12])
                4'd1: begin
                    r = quiet(6, pc, ir); r.d_addr = ir[11:4]; r.ra = ir[3:0]; r.d_wr = 1'b1;
                    exp_q.push_back(r);
                end
                4'd2: begin
                    r = quiet(4, pc, ir); r.d_addr = ir[11:4]; r.rf_s = 1'b1; r.wa = ir[3:0];
                    exp_q.push_back(r);
                    r.st = 4'd5; r.wen = 1'b1;
                    exp_q.push_back(r);
                end
                4'd3, 4'd4: begin
                    r = quiet((ir[15:12] == 4'd3) ? 7 : 8, pc, ir);
                    r.ra = ir[11:8]; r.rb = ir[7:4]; r.wa = ir[3:0]; r.wen = 1'b1;
                    r.alu = (ir[15:12] == 4'd3) ? 3'd1 : 3'd2;
                    exp_q.push_back(r);
                end
                4'd5: while (exp_q.size() < n) exp_q.push_back(quiet(9, pc, ir));
                default: exp_q.push_back(quiet(3, pc, ir));
            endcase
        end
    endtask

    task automatic start(input int n);
        build_expect(n);
        @(negedge Clk); Reset_n = 1'b0;
        @(negedge Clk); Reset_n = 1'b1;
        #1;
    endtask

    task automatic fill_noop();
        for (int i = 0; i < 32; i++) rom[i] = 16'h0000;
    endtask

    task automatic test_reset();
        obs_t r;
        fill_noop(); rom[0] = 16'h2A53;
        start(5);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) begin @(negedge Clk); #1; end
            tests++;
            if (obs !== exp_q[k]) begin failed++; $display("FAIL reset_pre cyc%0d got %h want %h", k, obs, exp_q[k]); end
        end
        tests++;
        if (RF_W_en !== 1'b1) begin failed++; $display("FAIL reset_loadb_wen got %b want 1", RF_W_en); end
        Reset_n = 1'b0; #1;
        tests++;
        if (obs !== quiet(0, 0, 16'h0)) begin failed++; $display("FAIL reset_abort got %h want %h", obs, quiet(0, 0, 16'h0)); end
        @(negedge Clk); Reset_n = 1'b1; #1;
        tests++;
        if (obs !== quiet(0, 0, 16'h0)) begin failed++; $display("FAIL reset_init got %h want %h", obs, quiet(0, 0, 16'h0)); end
        @(negedge Clk); #1;
        r = quiet(1, 0, 16'h0); r.i_rd = 1'b1;
        tests++;
        if (obs !== r) begin failed++; $display("FAIL reset_fetch got %h want %h", obs, r); end
    endtask

    task automatic test_load();
        fill_noop(); rom[0] = 16'h2A53;
        start(9);
        for (int k = 0; k < 9; k++) begin
            if (k > 0) begin @(negedge Clk); #1; end
            tests++;
            if (obs !== exp_q[k]) begin failed++; $display("FAIL load cyc%0d got %h want %h", k, obs, exp_q[k]); end
        end
    endtask

    task automatic test_add_sub();
        fill_noop(); rom[0] = 16'h3126; rom[1] = 16'h4126;
        start(10);
        for (int k = 0; k < 10; k++) begin
            if (k > 0) begin @(negedge Clk); #1; end
            tests++;
            if (obs !== exp_q[k]) begin failed++; $display("FAIL add_sub cyc%0d got %h want %h", k, obs, exp_q[k]); end
        end
    endtask

    task automatic test_store_noop_illegal();
        fill_noop(); rom[0] = 16'h10F7; rom[1] = 16'h0000; rom[2] = 16'hE123;
        start(12);
        for (int k = 0; k < 12; k++) begin
            if (k > 0) begin @(negedge Clk); #1; end
            tests++;
            if (obs !== exp_q[k]) begin failed++; $display("FAIL store_noop cyc%0d got %h want %h", k, obs, exp_q[k]); end
        end
    endtask

    task automatic test_halt();
        fill_noop(); rom[2] = 16'h5000; rom[3] = 16'h3126;
        start(34);
        for (int k = 0; k < 34; k++) begin
            if (k > 0) begin @(negedge Clk); #1; end
            tests++;
            if (obs !== exp_q[k]) begin failed++; $display("FAIL halt cyc%0d got %h want %h", k, obs, exp_q[k]); end
        end
    endtask

    task automatic test_wrap();
        fill_noop(); rom[0] = 16'h3456;
        start(104);
        for (int k = 0; k < 104; k++) begin
            if (k > 0) begin @(negedge Clk); #1; end
            tests++;
            if (obs !== exp_q[k]) begin failed++; $display("FAIL wrap cyc%0d got %h want %h", k, obs, exp_q[k]); end
        end
    endtask

    task automatic test_random();
        logic [3:0] op;
        for (int p = 0; p < 6; p++) begin
            for (int i = 0; i < 32; i++) begin
                rom[i] = 16'($urandom);
                op = 4'($urandom_range(0, 15));
                if (op == 4'd5 && $urandom_range(0, 3) != 0) op = 4'd2;
                rom[i][15:12] = op;
            end
            start(120);
            for (int k = 0; k < 120; k++) begin
                if (k > 0) begin @(negedge Clk); #1; end
                tests++;
                if (obs !== exp_q[k]) begin failed++; $display("FAIL random p%0d cyc%0d got %h want %h", p, k, obs, exp_q[k]); end
            end
        end
    endtask

    initial begin
        fill_noop();
        test_reset();
        test_load();
        test_add_sub();
        test_store_noop_illegal();
        test_halt();
        test_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
